// File: rtl/bit_serial_word_sink.sv
// Deserialises an MSB-first bit-serial stream into parallel words and buffers
// them in a two-entry FIFO behind a valid/ready port, with sticky error flags.
module bit_serial_word_sink #(
  parameter int w_word = 32,
  parameter int depth  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      bclk,
  input  logic [$clog2(w_word)-1:0] counter,
  input  logic                      in,
  output logic [w_word-1:0]         word_data,
  output logic                      word_valid,
  input  logic                      word_ready,
  output logic                      overflow,
  output logic                      sync_err,
  input  logic                      clr_flags
);

  localparam int cw = $clog2(w_word);
  localparam logic [cw-1:0] last_idx = cw'(w_word - 1);

  if (w_word < 2) begin : g_bad_width
    $error("bit_serial_word_sink: w_word must be at least 2");
  end
  if (depth != 2) begin : g_bad_depth
    $error("bit_serial_word_sink: depth is fixed at 2");
  end

  logic              bclk_prev;
  logic [w_word-1:0] shreg, shreg_nxt;
  logic [cw-1:0]     exp_idx, exp_nxt;
  logic [w_word-1:0] mem0, mem1, mem0_nxt, mem1_nxt;
  logic [1:0]        count, count_nxt;
  logic              rec, pop, push, sync_set, ovf_set;
  logic [w_word-1:0] push_word;

  assign word_valid = (count != 2'd0);
  assign word_data  = mem0;

  // Bit capture: exp_idx == 0 means idle, waiting for a counter==0 start bit.
  always_comb begin
    rec       = bclk & ~bclk_prev;
    push_word = {shreg[w_word-2:0], in};
    push      = 1'b0;
    sync_set  = 1'b0;
    shreg_nxt = shreg;
    exp_nxt   = exp_idx;
    if (rec) begin
      if (counter == '0) begin
        shreg_nxt = {{(w_word-1){1'b0}}, in};
        exp_nxt   = cw'(1);
        sync_set  = (exp_idx != '0);
      end else if (counter == exp_idx) begin
        shreg_nxt = push_word;
        if (counter == last_idx) begin
          push    = 1'b1;
          exp_nxt = '0;
        end else begin
          exp_nxt = exp_idx + cw'(1);
        end
      end else begin
        sync_set  = 1'b1;
        shreg_nxt = '0;
        exp_nxt   = '0;
      end
    end
  end

  // Output FIFO: the pop is applied before the push, so a full FIFO that is
  // drained on the same edge still accepts the new word.
  always_comb begin
    pop       = word_valid & word_ready;
    mem0_nxt  = mem0;
    mem1_nxt  = mem1;
    count_nxt = count;
    ovf_set   = 1'b0;
    if (pop && push) begin
      if (count == 2'd2) begin
        mem0_nxt = mem1;
        mem1_nxt = push_word;
      end else begin
        mem0_nxt = push_word;
      end
    end else if (pop) begin
      if (count == 2'd2) mem0_nxt = mem1;
      count_nxt = count - 2'd1;
    end else if (push) begin
      if (count == 2'd0) begin
        mem0_nxt  = push_word;
        count_nxt = 2'd1;
      end else if (count == 2'd1) begin
        mem1_nxt  = push_word;
        count_nxt = 2'd2;
      end else begin
        ovf_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_prev <= 1'b0;
      shreg     <= '0;
      exp_idx   <= '0;
      mem0      <= '0;
      mem1      <= '0;
      count     <= 2'd0;
      overflow  <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      bclk_prev <= bclk;
      shreg     <= shreg_nxt;
      exp_idx   <= exp_nxt;
      mem0      <= mem0_nxt;
      mem1      <= mem1_nxt;
      count     <= count_nxt;
      overflow  <= (overflow & ~clr_flags) | ovf_set;
      sync_err  <= (sync_err & ~clr_flags) | sync_set;
    end
  end

endmodule

// File: tb/tb_bit_serial_word_sink.sv
// Bench for bit_serial_word_sink: directed scenarios plus a randomized phase,
// all cycles checked against a queue-based reference model.
module tb_bit_serial_word_sink;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         bclk = 1'b0;
  logic [4:0]   counter = '0;
  logic         din = 1'b0;
  logic         word_ready = 1'b0;
  logic         clr_flags = 1'b0;
  logic [W-1:0] word_data;
  logic         word_valid;
  logic         overflow;
  logic         sync_err;

  always #5 clk = ~clk;

  bit_serial_word_sink #(.w_word(W), .depth(2)) dut (
    .clk(clk), .rst_n(rst_n), .bclk(bclk), .counter(counter), .in(din),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .overflow(overflow), .sync_err(sync_err), .clr_flags(clr_flags)
  );

  int n_err = 0;
  int n_checks = 0;
  bit rand_ready = 1'b0;
  bit rand_clr = 1'b0;

  logic         bits_m[$];
  logic [W-1:0] q_m[$];
  logic [W-1:0] head_m = '0;
  logic         ovf_m = 1'b0;
  logic         se_m = 1'b0;
  logic         bclk_pm = 1'b0;
  logic [W-1:0] dut_log[$];

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] logv(int i);
    if (i < dut_log.size()) return dut_log[i];
    return 'x;
  endfunction

  task automatic model_reset();
    bits_m.delete();
    q_m.delete();
    head_m = '0;
    ovf_m = 1'b0;
    se_m = 1'b0;
    bclk_pm = 1'b0;
  endtask

  // Reference: bits collected in a queue; a word is complete once W in-order bits arrived.
  task automatic model_step();
    logic pop, rec, push, ovf, se;
    logic [W-1:0] w;
    pop = (q_m.size() != 0) && word_ready;
    rec = bclk && !bclk_pm;
    bclk_pm = bclk;
    push = 1'b0; ovf = 1'b0; se = 1'b0; w = '0;
    if (rec) begin
      if (counter == 0) begin
        if (bits_m.size() != 0) se = 1'b1;
        bits_m.delete();
        bits_m.push_back(din);
      end else if (bits_m.size() != 0 && int'(counter) == bits_m.size()) begin
        bits_m.push_back(din);
      end else begin
        se = 1'b1;
        bits_m.delete();
      end
      if (bits_m.size() == W) begin
        foreach (bits_m[i]) w = (w << 1) | W'(bits_m[i]);
        push = 1'b1;
        bits_m.delete();
      end
    end
    if (pop) void'(q_m.pop_front());
    if (push) begin
      if (q_m.size() < 2) q_m.push_back(w);
      else ovf = 1'b1;
    end
    ovf_m = (ovf_m && !clr_flags) || ovf;
    se_m  = (se_m && !clr_flags) || se;
    if (q_m.size() != 0) head_m = q_m[0];
  endtask

  task automatic cycle();
    logic dp;
    logic [W-1:0] dv;
    if (rand_ready) word_ready = 1'($urandom_range(0, 1));
    if (rand_clr) clr_flags = ($urandom_range(0, 7) == 0);
    dp = word_valid && word_ready;
    dv = word_data;
    @(posedge clk);
    model_step();
    if (dp) dut_log.push_back(dv);
    #1;
    chk("valid", W'(word_valid), W'(q_m.size() != 0));
    chk("data", word_data, head_m);
    chk("overflow", W'(overflow), W'(ovf_m));
    chk("sync_err", W'(sync_err), W'(se_m));
  endtask

  task automatic send_bits(logic [W-1:0] v, int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      bclk = 1'b1; counter = 5'(i); din = v[W-1-i];
      cycle();
      bclk = 1'b0;
      cycle();
    end
  endtask

  task automatic send_bad(int idx);
    bclk = 1'b1; counter = 5'(idx); din = 1'($urandom_range(0, 1));
    cycle();
    bclk = 1'b0;
    cycle();
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    cycle();
    clr_flags = 1'b0;
  endtask

  initial begin
    logic [W-1:0] v;
    #2;
    chk("rst_valid", W'(word_valid), '0);
    chk("rst_data", word_data, '0);
    chk("rst_flags", W'({overflow, sync_err}), '0);
    #10 rst_n = 1'b1;

    // single word, ready high: one-cycle valid pulse
    word_ready = 1'b1;
    dut_log.delete();
    send_bits(32'hDEADBEEF, 0, 30);
    bclk = 1'b1; counter = 5'd31; din = 1'b1;
    cycle();
    chk("t1_valid_rise", W'(word_valid), 1);
    chk("t1_data", word_data, 32'hDEADBEEF);
    bclk = 1'b0;
    cycle();
    chk("t1_valid_fall", W'(word_valid), 0);
    chk("t1_log", logv(0), 32'hDEADBEEF);
    chk("t1_flags", W'({overflow, sync_err}), 0);

    // fill FIFO, drop the third word
    word_ready = 1'b0;
    dut_log.delete();
    send_bits(32'h00000001, 0, 31);
    send_bits(32'h80000000, 0, 31);
    chk("t2_valid", W'(word_valid), 1);
    chk("t2_head", word_data, 32'h00000001);
    send_bits(32'h12345678, 0, 31);
    chk("t2_overflow", W'(overflow), 1);
    chk("t2_head_hold", word_data, 32'h00000001);
    word_ready = 1'b1;
    repeat (3) cycle();
    chk("t2_count", W'(dut_log.size()), 2);
    chk("t2_pop0", logv(0), 32'h00000001);
    chk("t2_pop1", logv(1), 32'h80000000);
    chk("t2_empty", W'(word_valid), 0);
    chk("t2_hold_last", word_data, 32'h80000000);
    pulse_clr();
    chk("t2_clr", W'(overflow), 0);

    // push into full FIFO on the same edge as a pop
    word_ready = 1'b0;
    dut_log.delete();
    send_bits(32'h00000001, 0, 31);
    send_bits(32'h80000000, 0, 31);
    send_bits(32'h12345678, 0, 30);
    bclk = 1'b1; counter = 5'd31; din = 1'b0; word_ready = 1'b1;
    cycle();
    bclk = 1'b0;
    repeat (3) cycle();
    chk("t3_overflow", W'(overflow), 0);
    chk("t3_count", W'(dut_log.size()), 3);
    chk("t3_pop0", logv(0), 32'h00000001);
    chk("t3_pop1", logv(1), 32'h80000000);
    chk("t3_pop2", logv(2), 32'h12345678);

    // index jump
    dut_log.delete();
    send_bits($urandom, 0, 9);
    send_bad(15);
    chk("t4_sync", W'(sync_err), 1);
    chk("t4_nopush", W'(word_valid), 0);
    send_bits(32'hCAFEF00D, 0, 31);
    chk("t4_count", W'(dut_log.size()), 1);
    chk("t4_word", logv(0), 32'hCAFEF00D);
    pulse_clr();
    chk("t4_clr", W'(sync_err), 0);

    // restart at 0 mid-word
    dut_log.delete();
    send_bits($urandom, 0, 9);
    send_bits(32'hA5A5A5A5, 0, 31);
    repeat (2) cycle();
    chk("t5_sync", W'(sync_err), 1);
    chk("t5_count", W'(dut_log.size()), 1);
    chk("t5_word", logv(0), 32'hA5A5A5A5);
    pulse_clr();

    // async reset mid-word with a buffered word and a flag set
    word_ready = 1'b0;
    send_bits($urandom, 0, 4);
    send_bad(9);
    send_bits(32'h11111111, 0, 31);
    send_bits($urandom, 0, 12);
    chk("t6_pre_valid", W'(word_valid), 1);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_valid", W'(word_valid), 0);
    chk("t6_rst_data", word_data, '0);
    chk("t6_rst_flags", W'({overflow, sync_err}), 0);
    bclk = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    word_ready = 1'b1;
    dut_log.delete();
    send_bits(32'h0F0F0F0F, 0, 31);
    cycle();
    chk("t6_count", W'(dut_log.size()), 1);
    chk("t6_word", logv(0), 32'h0F0F0F0F);
    chk("t6_flags", W'({overflow, sync_err}), 0);

    // randomized words, ready and flag clears
    rand_ready = 1'b1;
    rand_clr = 1'b1;
    for (int n = 0; n < 40; n++) begin
      v = $urandom;
      send_bits(v, 0, 31);
      repeat ($urandom_range(0, 2)) cycle();
    end
    rand_ready = 1'b0;
    rand_clr = 1'b0;
    word_ready = 1'b1;
    clr_flags = 1'b0;
    repeat (4) cycle();
    chk("rand_drained", W'(word_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/bit_serial_word_sink.md
Name: bit_serial_word_sink

Overview:
- Receiving end of the bit-serial datapath stream: deserialises the MSB-first bit stream produced by the bit-serial SHA-256 units into parallel words.
- Bits are recorded on bclk rising edges, with the same bit index counter as the bit-serial cores.
- Assembled words are buffered in a 2-entry FIFO and presented on a valid/ready parallel port to the host/digest logic.
- Sticky flags report overflow and bit-index desynchronisation.

Parameters:
- w_word, 32, word width in bits (≥ 2).
- depth, 2, output FIFO entries (fixed at 2; parameter exists for range checks only).

Ports:
- clk  input  1  system clock; all state changes on posedge clk.
- rst_n  input  1  asynchronous active-low reset.
- bclk  input  1  bit clock, synchronous to clk; rising edge = record bit.
- counter  input  $clog2(w_word)  index of the current bit, 0 = MSB.
- in  input  1  serial data bit.
- word_data  output  w_word  head-of-FIFO word.
- word_valid  output  1  FIFO non-empty.
- word_ready  input  1  consumer accepts head word.
- overflow  output  1  sticky: a completed word was dropped because the FIFO was full.
- sync_err  output  1  sticky: counter did not match the expected index.
- clr_flags  input  1  clears overflow and sync_err.

Behaviour:
- Reset (async, rst_n=0): bclk_prev=0, shift register=0, expected index=0, FIFO empty.
  - Outputs: word_valid=0, word_data=0, overflow=0, sync_err=0.
  - Reset mid-word discards the partial word and all buffered words.
- Edge detect: bclk_prev is registered each clk. A record event occurs when bclk_prev=0 and bclk=1. Nothing happens on falling edges.
- On a record event:
  - If counter==0: start a new word. Shift register gets in at the LSB with the upper bits cleared; expected index becomes 1.
    - If expected index was not 0 (partial word in progress), set sync_err and discard that partial word.
  - Else if counter==expected index: shift left, in into the LSB, expected index +1.
  - Else: set sync_err, discard the partial word, expected index becomes 0. Bits are ignored until the next counter==0.
  - If counter==w_word-1 and it matched: the word is complete.
    - Push {shift_reg[w_word-2:0], in} into the FIFO on that same clk edge.
    - word_valid rises on the next clk when the FIFO was empty (latency 1 clk after the record edge).
    - Expected index wraps to 0.
- FIFO handshake:
  - A pop occurs when word_valid && word_ready at a posedge.
  - word_data always equals the head entry and is stable while valid && !ready.
  - word_data holds its last value when empty (0 after reset).
- Push when full:
  - If a pop occurs on the same edge, the pop is applied first and the push is accepted. Count stays 2 and order is preserved.
  - Otherwise the word is dropped and overflow is set.
- Push and pop on the same edge while count is 1: count stays 1 and the new word becomes the head.
- clr_flags=1 clears both flags at the next posedge. If a flag-setting event occurs on the same edge, the set wins.
- A bclk rising edge that occurs when the previous one was only 1 clk earlier is still honoured; no minimum bclk period is enforced beyond 2 clk per bclk cycle.

Test Plan:
- Stream 0xDEADBEEF MSB-first with counter 0..31, word_ready=1 → word_valid pulses 1 clk starting 1 clk after the 32nd rising bclk edge, word_data=0xDEADBEEF, flags stay 0.
- Stream 0x00000001, 0x80000000, 0x12345678 with word_ready=0 → after 2 words word_valid=1 and head=0x00000001. Third word dropped, overflow=1. Then ready=1 → pops 0x00000001, then 0x80000000, then word_valid=0.
- Count=2, third word completes on the same clk that word_ready=1 pops → no overflow. Output order is 0x00000001, 0x80000000, 0x12345678.
- Counter sequence 0..9 then 15 → sync_err=1, no word pushed. A subsequent clean 0..31 stream of 0xCAFEF00D is delivered correctly. clr_flags=1 → sync_err=0 next clk.
- Restart at counter 0 after 10 bits, then a full word 0xA5A5A5A5 → sync_err=1, and exactly one word 0xA5A5A5A5 is output.
- Assert rst_n=0 asynchronously mid-word with one word buffered → word_valid=0 immediately and flags are 0. After release, a full word 0x0F0F0F0F is delivered intact.
